// File: rtl/rainbow_sequencer.sv
// Rainbow pattern sequencer for the 6-stage RGB LED shift register: fast prime, then timed steps.
// Optional RAINBOW_SPEED_ADJUST_EN adds faster/slower inputs that shorten the step interval.
module rainbow_sequencer #(
  parameter int STEP_CYCLES = 2000000,
  parameter int PATTERN_LEN = 6,
  parameter int ONES        = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           hold,
`ifdef RAINBOW_SPEED_ADJUST_EN
  input  logic                           faster,
  input  logic                           slower,
`endif
  output logic                           shift_en,
  output logic                           d,
  output logic [$clog2(PATTERN_LEN)-1:0] phase,
  output logic                           running,
  output logic                           cycle_done
);

  localparam int PW  = $clog2(STEP_CYCLES);
  localparam int PHW = $clog2(PATTERN_LEN);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_PAUSE} state_t;

  state_t          state_q;
  logic [PW-1:0]   presc_q;
  logic [PHW-1:0]  phase_q;
  logic            shift_en_q;
  logic            d_q;
  logic            running_q;
  logic            cycle_done_q;

  logic [PHW-1:0]  phase_d;
  logic            phase_wrap;
  logic            pat_bit;
  logic [31:0]     interval;
  logic            step_hit;

`ifdef RAINBOW_SPEED_ADJUST_EN
  logic [1:0]      speed_q;
  logic [31:0]     shifted;

  // Speed level: saturating up/down, simultaneous requests cancel; survives stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_q <= 2'd0;
    end else if (faster && !slower && (speed_q != 2'd3)) begin
      speed_q <= speed_q + 2'd1;
    end else if (slower && !faster && (speed_q != 2'd0)) begin
      speed_q <= speed_q - 2'd1;
    end else begin
      speed_q <= speed_q;
    end
  end

  always_comb begin
    shifted  = 32'(STEP_CYCLES) >> speed_q;
    interval = (shifted < 32'd2) ? 32'd2 : shifted;
  end
`else
  always_comb begin
    interval = 32'(STEP_CYCLES);
  end
`endif

  // Compare with >= so a shortened interval fires at once if the count is already past it.
  always_comb begin
    phase_wrap = (phase_q == PHW'(PATTERN_LEN - 1));
    phase_d    = phase_wrap ? '0 : phase_q + PHW'(1);
    pat_bit    = (32'(phase_q) < 32'(ONES));
    step_hit   = (32'(presc_q) >= (interval - 32'd1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      phase_q      <= '0;
      shift_en_q   <= 1'b0;
      d_q          <= 1'b0;
      running_q    <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      shift_en_q   <= 1'b0;
      d_q          <= 1'b0;
      cycle_done_q <= 1'b0;
      if (stop) begin
        state_q   <= S_IDLE;
        presc_q   <= '0;
        phase_q   <= '0;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            running_q <= 1'b0;
            if (start) begin
              state_q <= S_PRIME;
              phase_q <= '0;
              presc_q <= '0;
            end
          end
          S_PRIME: begin
            shift_en_q <= 1'b1;
            d_q        <= pat_bit;
            phase_q    <= phase_d;
            if (phase_wrap) begin
              cycle_done_q <= 1'b1;
              state_q      <= S_RUN;
              presc_q      <= '0;
              running_q    <= 1'b1;
            end
          end
          S_RUN: begin
            if (step_hit) begin
              shift_en_q   <= 1'b1;
              d_q          <= pat_bit;
              cycle_done_q <= phase_wrap;
              phase_q      <= phase_d;
              presc_q      <= '0;
            end else begin
              presc_q <= presc_q + PW'(1);
            end
            // The hold cycle itself still counts as a RUN cycle.
            if (hold) begin
              state_q   <= S_PAUSE;
              running_q <= 1'b0;
            end
          end
          S_PAUSE: begin
            if (hold) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          default: begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign shift_en   = shift_en_q;
  assign d          = d_q;
  assign phase      = phase_q;
  assign running    = running_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_rainbow_sequencer.sv
// Directed bench for rainbow_sequencer with a timed pulse scoreboard.
// Exercises the RAINBOW_SPEED_ADJUST_EN ports when that macro is defined.
module tb_rainbow_sequencer;

  localparam int STEP = 4;
  localparam int LEN  = 6;
  localparam int NONE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       hold = 1'b0;
`ifdef RAINBOW_SPEED_ADJUST_EN
  logic       faster = 1'b0;
  logic       slower = 1'b0;
`endif
  logic       shift_en;
  logic       d;
  logic [2:0] phase;
  logic       running;
  logic       cycle_done;

  typedef struct {
    int         t;
    logic       d;
    logic       cd;
    logic [2:0] ph;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  rainbow_sequencer #(.STEP_CYCLES(STEP), .PATTERN_LEN(LEN), .ONES(NONE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
`ifdef RAINBOW_SPEED_ADJUST_EN
    .faster     (faster),
    .slower     (slower),
`endif
    .shift_en   (shift_en),
    .d          (d),
    .phase      (phase),
    .running    (running),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int t, input logic dv, input logic cd, input logic [2:0] ph);
    exp_t e;
    e.t = t; e.d = dv; e.cd = cd; e.ph = ph;
    q.push_back(e);
  endtask

  // Compare this cycle's outputs with the head of the scoreboard.
  task automatic check_cycle();
    bit   exp_now;
    exp_t e;
    exp_now = (q.size() > 0) && (q[0].t == cyc);
    chk($sformatf("shift_en@%0d", cyc), 32'(shift_en), 32'(exp_now));
    if (exp_now) begin
      e = q.pop_front();
      chk($sformatf("d@%0d", cyc), 32'(d), 32'(e.d));
      chk($sformatf("cycle_done@%0d", cyc), 32'(cycle_done), 32'(e.cd));
      chk($sformatf("phase@%0d", cyc), 32'(phase), 32'(e.ph));
    end else begin
      chk($sformatf("cycle_done_quiet@%0d", cyc), 32'(cycle_done), 32'd0);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_cycle();
    end
  endtask

  // Pulse start, expect a 6-bit prime then nrun steps spaced by interval.
  task automatic start_and_run(input int interval, input int nrun);
    int s;
    start = 1'b1;
    step(1);
    start = 1'b0;
    s = cyc;
    for (int i = 0; i < LEN; i++)
      push(s + 1 + i, (i < NONE), (i == LEN - 1), 3'((i + 1) % LEN));
    for (int k = 0; k < nrun; k++)
      push(s + LEN + interval * (k + 1), ((k % LEN) < NONE), ((k % LEN) == LEN - 1), 3'((k + 1) % LEN));
    step(1);
    chk("running_in_prime", 32'(running), 32'd0);
    step(LEN);
    chk("running_after_prime", 32'(running), 32'd1);
    step(s + LEN + interval * nrun - cyc);
  endtask

  initial begin
    int r;
    // Reset held for three cycles, then idle.
    @(negedge clk);
    step(3);
    chk("reset_shift_en", 32'(shift_en), 32'd0);
    chk("reset_phase", 32'(phase), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_d", 32'(d), 32'd0);
    reset = 1'b0;
    step(10);
    chk("idle_phase", 32'(phase), 32'd0);
    chk("idle_running", 32'(running), 32'd0);

    // Prime then eight RUN steps.
    start_and_run(STEP, 8);
    chk("phase_after_run", 32'(phase), 32'd2);

    // Pause two cycles after a step, resume after ten.
    step(1);
    hold = 1'b1;
    step(1);
    hold = 1'b0;
    chk("running_paused", 32'(running), 32'd0);
    step(10);
    chk("phase_frozen", 32'(phase), 32'd2);
    chk("running_still_paused", 32'(running), 32'd0);
    hold = 1'b1;
    step(1);
    hold = 1'b0;
    r = cyc;
    chk("running_resumed", 32'(running), 32'd1);
    push(r + 2, 1'b1, 1'b0, 3'd3);
    push(r + 2 + STEP, 1'b0, 1'b0, 3'd4);
    step(2 + STEP);

    // stop beats start in the same cycle.
    step(1);
    stop = 1'b1;
    start = 1'b1;
    step(1);
    stop = 1'b0;
    start = 1'b0;
    chk("stop_start_phase", 32'(phase), 32'd0);
    chk("stop_start_running", 32'(running), 32'd0);
    step(10);

    // stop after three prime pulses.
    start = 1'b1;
    step(1);
    start = 1'b0;
    r = cyc;
    for (int i = 0; i < 3; i++) push(r + 1 + i, 1'b1, 1'b0, 3'(i + 1));
    step(3);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("prime_stop_phase", 32'(phase), 32'd0);
    chk("prime_stop_running", 32'(running), 32'd0);
    step(8);

    // Asynchronous reset between edges on the 4th prime cycle.
    start = 1'b1;
    step(1);
    start = 1'b0;
    r = cyc;
    for (int i = 0; i < 4; i++) push(r + 1 + i, (i < NONE), 1'b0, 3'(i + 1));
    step(4);
    #1 reset = 1'b1;
    #1;
    chk("async_shift_en", 32'(shift_en), 32'd0);
    chk("async_phase", 32'(phase), 32'd0);
    chk("async_d", 32'(d), 32'd0);
    chk("async_running", 32'(running), 32'd0);
    step(2);
    reset = 1'b0;
    step(10);

`ifdef RAINBOW_SPEED_ADJUST_EN
    // Saturate speed at 3: interval floors at 2.
    for (int i = 0; i < 4; i++) begin
      faster = 1'b1;
      step(1);
      faster = 1'b0;
      step(1);
    end
    start_and_run(2, 4);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    slower = 1'b1;
    step(1);
    slower = 1'b0;
    start_and_run(2, 4);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      slower = 1'b1;
      step(1);
      slower = 1'b0;
      step(1);
    end
    start_and_run(4, 4);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(4);
`endif

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
